// File: rtl/noc_packetizer.sv
// NoC packetizer: turns a request plus payload words into head/body/tail flits.
// Optional statistics counters are enabled with the NOC_PKT_STATS_EN macro.
module noc_packetizer #(
  parameter int FLIT_W  = 32,
  parameter int MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_dest,
  input  logic [3:0]        req_len,
  input  logic [7:0]        req_tag,
  output logic              req_ready,
  input  logic              pld_valid,
  input  logic [FLIT_W-5:0] pld_data,
  output logic              pld_ready,
  output logic              flit_valid,
  output logic [FLIT_W-1:0] flit_data,
  input  logic              flit_ready,
  output logic              err_len
`ifdef NOC_PKT_STATS_EN
  ,
  output logic [15:0]       pkt_count,
  output logic [31:0]       flit_count
`endif
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

  state_t            state, state_nxt;
  logic [1:0]        dest_p0;
  logic [3:0]        len_p0;
  logic [3:0]        rem_p1;
  logic              vld_p1;
  logic [FLIT_W-1:0] flit_p1;
  logic              req_fire, pld_fire, flit_fire;
  logic [3:0]        eff_len;
  logic [FLIT_W-1:0] head_flit, body_flit;

  function automatic logic [3:0] sat_len(input logic [3:0] len);
    return (len > MAX_LEN_L) ? MAX_LEN_L : len;
  endfunction

  assign eff_len   = sat_len(req_len);
  assign req_ready = (state == IDLE) && !vld_p1;
  assign pld_ready = (state == BODY) && (rem_p1 != 4'd0) && (!vld_p1 || flit_ready);
  assign req_fire  = req_valid && req_ready;
  assign pld_fire  = pld_valid && pld_ready;
  assign flit_fire = vld_p1 && flit_ready;

  always_comb begin
    head_flit        = '0;
    head_flit[1:0]   = req_dest;
    head_flit[3:2]   = (eff_len == 4'd0) ? 2'b00 : 2'b01;
    head_flit[7:4]   = eff_len;
    head_flit[15:8]  = req_tag;
  end

  // the word loaded while one body flit remains is the tail
  assign body_flit = {pld_data, (rem_p1 == 4'd1) ? 2'b11 : 2'b10, dest_p0};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = HEAD;
      HEAD:    if (flit_fire) state_nxt = (len_p0 == 4'd0) ? IDLE : BODY;
      BODY:    if (flit_fire && rem_p1 == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output stage: head from the accepted request, body/tail from payload words
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      flit_p1 <= '0;
      err_len <= 1'b0;
      rem_p1  <= 4'd0;
      len_p0  <= 4'd0;
      dest_p0 <= 2'b00;
    end else begin
      err_len <= 1'b0;
      if (req_fire) begin
        dest_p0 <= req_dest;
        len_p0  <= eff_len;
        err_len <= (req_len > MAX_LEN_L);
        flit_p1 <= head_flit;
        vld_p1  <= 1'b1;
      end else if (pld_fire) begin
        flit_p1 <= body_flit;
        vld_p1  <= 1'b1;
      end else if (flit_fire) begin
        vld_p1  <= 1'b0;
      end
      if (state == HEAD && flit_fire) rem_p1 <= len_p0;
      else if (pld_fire)              rem_p1 <= rem_p1 - 4'd1;
    end
  end

  assign flit_valid = vld_p1;
  assign flit_data  = flit_p1;

`ifdef NOC_PKT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count  <= 16'd0;
      flit_count <= 32'd0;
    end else if (flit_fire) begin
      flit_count <= flit_count + 32'd1;
      if (flit_p1[3:2] == 2'b00 || flit_p1[3:2] == 2'b11)
        pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer with an expected-flit scoreboard queue.
module tb_noc_packetizer;
  localparam int FLIT_W  = 32;
  localparam int MAX_LEN = 8;
  localparam int PW      = FLIT_W - 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [1:0]        req_dest = '0;
  logic [3:0]        req_len = '0;
  logic [7:0]        req_tag = '0;
  logic              req_ready;
  logic              pld_valid = 1'b0;
  logic [PW-1:0]     pld_data = '0;
  logic              pld_ready;
  logic              flit_valid;
  logic [FLIT_W-1:0] flit_data;
  logic              flit_ready = 1'b1;
  logic              err_len;
`ifdef NOC_PKT_STATS_EN
  logic [15:0]       pkt_count;
  logic [31:0]       flit_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];

  noc_packetizer #(.FLIT_W(FLIT_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dest(req_dest), .req_len(req_len), .req_tag(req_tag),
    .req_ready(req_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_ready(pld_ready),
    .flit_valid(flit_valid), .flit_data(flit_data), .flit_ready(flit_ready),
    .err_len(err_len)
`ifdef NOC_PKT_STATS_EN
    , .pkt_count(pkt_count), .flit_count(flit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_head(input logic [1:0] d, input logic [3:0] l,
                                           input logic [7:0] t);
    logic [3:0] eff;
    eff = (l > 4'(MAX_LEN)) ? 4'(MAX_LEN) : l;
    return {16'h0, t, eff, (eff == 4'd0) ? 2'b00 : 2'b01, d};
  endfunction

  function automatic logic [31:0] exp_body(input logic [1:0] d, input logic [PW-1:0] p,
                                           input bit tail);
    return {p, tail ? 2'b11 : 2'b10, d};
  endfunction

  // scoreboard: every flit handshake pops the oldest expected flit
  always @(negedge clk) begin
    if (flit_valid === 1'b1 && flit_ready === 1'b1) begin
      if (expq.size() == 0) chk("unexpected_flit_qsize", 32'(expq.size()), 32'd1);
      else                  chk("flit", flit_data, expq.pop_front());
    end
  end

  task automatic send_req(input logic [1:0] d, input logic [3:0] l, input logic [7:0] t,
                          input logic [31:0] e);
    int n = 0;
    expq.push_back(e);
    req_valid = 1'b1; req_dest = d; req_len = l; req_tag = t;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) chk("req_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_pld(input logic [PW-1:0] p, input logic [31:0] e);
    int n = 0;
    expq.push_back(e);
    pld_valid = 1'b1; pld_data = p;
    @(negedge clk);
    while (pld_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (pld_ready !== 1'b1) chk("pld_timeout", {31'b0, pld_ready}, 32'd1);
    @(posedge clk); #1;
    pld_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("drain_qsize", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int k;
    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_flit_valid", {31'b0, flit_valid}, 32'd0);
    chk("rst_flit_data", flit_data, 32'd0);
    chk("rst_err_len", {31'b0, err_len}, 32'd0);
    chk("rst_pld_ready", {31'b0, pld_ready}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // payload offered while idle is ignored
    pld_valid = 1'b1; pld_data = PW'(28'h0ABCDEF);
    repeat (3) begin
      @(negedge clk);
      chk("idle_pld_ready", {31'b0, pld_ready}, 32'd0);
      chk("idle_flit_valid", {31'b0, flit_valid}, 32'd0);
    end
    @(posedge clk); #1 pld_valid = 1'b0;

    // dest=2 len=3 tag=5A
    send_req(2'd2, 4'd3, 8'h5A, 32'h0000_5A36);
    chk("head_valid_latency", {31'b0, flit_valid}, 32'd1);
    chk("no_err_len", {31'b0, err_len}, 32'd0);
    send_pld(PW'(1), 32'h1A);
    send_pld(PW'(2), 32'h2A);
    send_pld(PW'(3), 32'h3E);
    drain();

    // head-only packet, then req_ready must come back within 2 cycles
    send_req(2'd1, 4'd0, 8'hFF, 32'h0000_FF01);
    k = 0;
    while (req_ready !== 1'b1 && k < 2) begin @(posedge clk); #1; k++; end
    chk("headonly_req_ready", {31'b0, req_ready}, 32'd1);
    drain();

    // clamped length: err_len one pulse, head length 8, 8 body flits
    send_req(2'd0, 4'd12, 8'h33, 32'h0000_3384);
    chk("err_len_pulse", {31'b0, err_len}, 32'd1);
    @(posedge clk); #1;
    chk("err_len_clear", {31'b0, err_len}, 32'd0);
    for (int i = 0; i < 8; i++)
      send_pld(PW'(i + 16), exp_body(2'd0, PW'(i + 16), i == 7));
    drain();

    // back-pressure for 5 cycles mid-body
    send_req(2'd3, 4'd4, 8'h11, exp_head(2'd3, 4'd4, 8'h11));
    send_pld(PW'(28'hAAAAAAA), exp_body(2'd3, PW'(28'hAAAAAAA), 1'b0));
    flit_ready = 1'b0;
    held = flit_data;
    pld_valid = 1'b1; pld_data = PW'(28'h5555555);
    req_valid = 1'b1; req_len = 4'd1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_flit_data", flit_data, held);
      chk("stall_flit_valid", {31'b0, flit_valid}, 32'd1);
      chk("stall_pld_ready", {31'b0, pld_ready}, 32'd0);
      chk("busy_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    flit_ready = 1'b1;
    send_pld(PW'(28'h5555555), exp_body(2'd3, PW'(28'h5555555), 1'b0));
    send_pld(PW'(28'h1234567), exp_body(2'd3, PW'(28'h1234567), 1'b0));
    send_pld(PW'(28'h7654321), exp_body(2'd3, PW'(28'h7654321), 1'b1));
    drain();

    // reset while the 2nd body flit is pending: partial packet discarded
    send_req(2'd1, 4'd4, 8'h22, exp_head(2'd1, 4'd4, 8'h22));
    send_pld(PW'(28'h0000101), exp_body(2'd1, PW'(28'h0000101), 1'b0));
    send_pld(PW'(28'h0000202), exp_body(2'd1, PW'(28'h0000202), 1'b0));
    flit_ready = 1'b0;
    rst = 1'b1;
    void'(expq.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_flit_valid", {31'b0, flit_valid}, 32'd0);
    chk("midrst_flit_data", flit_data, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    flit_ready = 1'b1;
    send_req(2'd2, 4'd3, 8'h5A, 32'h0000_5A36);
    send_pld(PW'(7), 32'h7A);
    send_pld(PW'(8), 32'h8A);
    send_pld(PW'(9), 32'h9E);
    drain();

    // three packets of length 2 after a clean reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      send_req(2'(p), 4'd2, 8'(p + 1), exp_head(2'(p), 4'd2, 8'(p + 1)));
      send_pld(PW'(p * 2 + 100), exp_body(2'(p), PW'(p * 2 + 100), 1'b0));
      send_pld(PW'(p * 2 + 101), exp_body(2'(p), PW'(p * 2 + 101), 1'b1));
    end
    drain();
`ifdef NOC_PKT_STATS_EN
    chk("pkt_count", {16'b0, pkt_count}, 32'd3);
    chk("flit_count", flit_count, 32'd9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/noc_packetizer.md
NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 Parameter FLIT_W, default 32, flit width in bits; SHALL be >= 16.
REQ-002 Parameter MAX_LEN, default 8, maximum body flits per packet; SHALL be in the range 1..15.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  packet request offered.
REQ-006 req_dest  input  2  destination router output port.
REQ-007 req_len  input  4  number of body flits, 0..15.
REQ-008 req_tag  input  8  transaction tag.
REQ-009 req_ready  output  1  request accepted when high with req_valid.
REQ-010 pld_valid  input  1  payload word offered.
REQ-011 pld_data  input  FLIT_W-4  payload word.
REQ-012 pld_ready  output  1  payload word accepted when high with pld_valid.
REQ-013 flit_valid  output  1  flit offered to router input port.
REQ-014 flit_data  output  FLIT_W  flit.
REQ-015 flit_ready  input  1  router credit; flit transferred when high with flit_valid.
REQ-016 err_len  output  1  one-cycle pulse on a clamped request.

Function
REQ-017 Every flit SHALL carry req_dest in [1:0] and type in [3:2]: 00 head-only, 01 head, 10 body, 11 tail.
REQ-018 Head flit SHALL place effective length in [7:4] and tag in [15:8]; bits [FLIT_W-1:16] SHALL be zero.
REQ-019 Body and tail flits SHALL place pld_data in [FLIT_W-1:4].
REQ-020 The FSM SHALL have states IDLE, HEAD and BODY; req_ready SHALL be 1 only in IDLE with flit_valid low.
REQ-021 IDLE->HEAD on req_valid&&req_ready; the registered head flit SHALL be valid on the next cycle (1-cycle latency).
REQ-022 The request SHALL latch dest, tag and effective length; effective length = min(req_len, MAX_LEN).
REQ-023 A request with req_len > MAX_LEN SHALL assert err_len for exactly one cycle.
REQ-024 When effective length = 0, the single flit SHALL be type 00, and HEAD->IDLE SHALL occur on its handshake.
REQ-025 Otherwise HEAD->BODY SHALL occur on the head handshake, with the remaining count = effective length.
REQ-026 pld_ready SHALL = (state==BODY) && (remaining>0) && (!flit_valid || flit_ready); it SHALL be combinational.
REQ-027 An accepted payload word SHALL load the output register on the next edge and decrement remaining.
REQ-028 The flit loaded when remaining was 1 SHALL be type 11; all others SHALL be type 10.
REQ-029 BODY->IDLE SHALL occur when the tail flit handshakes.
REQ-030 A back-to-back packet SHALL be accepted the cycle after the tail handshake (one-cycle bubble permitted).
REQ-031 flit_valid and flit_data SHALL hold stable while flit_valid && !flit_ready.
REQ-032 pld_valid outside BODY SHALL be ignored; req_valid outside IDLE SHALL be ignored and not lost (held by the source).

Reset
REQ-033 rst SHALL force state to IDLE and all counters to 0.
REQ-034 rst SHALL force flit_valid, err_len and pld_ready to 0, flit_data to 0, and req_ready to 1 on the cycle after rst deasserts.
REQ-035 rst asserted mid-packet SHALL discard the partial packet; no tail flit SHALL be emitted.

Configuration
REQ-036 Macro NOC_PKT_STATS_EN, when defined, SHALL add outputs pkt_count[15:0] and flit_count[31:0].
REQ-037 With NOC_PKT_STATS_EN, pkt_count SHALL increment on each type-00 or type-11 handshake, and flit_count on every flit handshake.
REQ-038 With NOC_PKT_STATS_EN, both counters SHALL wrap at 2^width and SHALL be cleared by rst.
REQ-039 Without NOC_PKT_STATS_EN, these ports and counters SHALL be absent, and function SHALL be otherwise identical.

Verification
REQ-040 Scenario: dest=2, len=3, tag=0x5A, payload 0x1,0x2,0x3, flit_ready=1 -> 4 flits: 0x5A36, 0x1A, 0x2A, 0x3E.
REQ-041 Scenario: dest=1, len=0, tag=0xFF -> single flit 0xFF01; req_ready high again within 2 cycles.
REQ-042 Scenario: len=12 with MAX_LEN=8 -> err_len pulses once; head length field = 8; 8 body flits, the last of type 11.
REQ-043 Scenario: flit_ready low 5 cycles mid-body -> flit_data stable, pld_ready low, no flit dropped or duplicated.
REQ-044 Scenario: rst pulsed after 2nd body flit -> flit_valid=0 next cycle; the following request is emitted cleanly.
REQ-045 Scenario: NOC_PKT_STATS_EN, 3 packets of len 2 -> pkt_count=3, flit_count=9.
